hazard_scoreboard: RTL

Parametrised load-use and multi-cycle interlock unit for the ID stage of the MIPS pipeline. It tracks every in-flight register write with a per-register countdown. It stalls PC and IF/ID and injects an ID/EX bubble while a source or destination of the ID instruction is still pending. It also covers configurable load latency, a multi-cycle mult/div unit with structural busy tracking, branch flush, a global memory hold, and a saturating stall-cycle performance counter.

---
 rtl/pipeline_pkg.sv | 30 +++
 rtl/reg_countdown.sv | 29 ++
 rtl/hazard_scoreboard.sv | 111 +++++++++++
 3 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: register index width,
// result-latency classes and a constant clog2 helper.
package pipeline_pkg;

  localparam int REG_W = 5;

  typedef enum logic [1:0] {
    LAT_ALU  = 2'd0,
    LAT_LOAD = 2'd1,
    LAT_MD   = 2'd2
  } lat_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  function automatic lat_e lat_class(
    input logic is_load,
    input logic is_md
  );
    if (is_load) return LAT_LOAD;
    if (is_md) return LAT_MD;
    return LAT_ALU;
  endfunction

endpackage

// File: rtl/reg_countdown.sv
// Load-or-decrement countdown; busy while nonzero.
// Ports: clk, rst (async low), en, ld, ld_val -> busy.
module reg_countdown #(
  parameter int CW = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          ld,
  input  logic [CW-1:0] ld_val,
  output logic          busy
);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (en) begin
      if (ld)
        cnt <= ld_val;
      else if (cnt != '0)
        cnt <= cnt - CW'(1);
    end
  end

  assign busy = (cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// ID-stage interlock: per-register pending countdowns,
// mult/div busy, flush/hold control, stall counter.
// Ports: clk, rst, id_* fields, flush, mem_hold ->
//   pc_write, if_id_write, id_ex_bubble, issue,
//   stall_cycles.
module hazard_scoreboard
  import pipeline_pkg::*;
#(
  parameter int REG_W    = pipeline_pkg::REG_W,
  parameter int LOAD_LAT = 1,
  parameter int MD_LAT   = 4,
  parameter int PERF_W   = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic [REG_W-1:0]  id_rd,
  input  logic              id_rd_we,
  input  logic              id_is_load,
  input  logic              id_is_md,
  input  logic              flush,
  input  logic              mem_hold,
  output logic              pc_write,
  output logic              if_id_write,
  output logic              id_ex_bubble,
  output logic              issue,
  output logic [PERF_W-1:0] stall_cycles
);

  localparam int NUM_REGS = 2 ** REG_W;
  localparam int MAX_LAT  =
    (LOAD_LAT > MD_LAT) ? LOAD_LAT : MD_LAT;
  localparam int CW = clog2(MAX_LAT + 1);

  logic [NUM_REGS-1:0] pend;
  logic                md_busy;
  logic                run;
  logic                raw;
  logic                waw;
  logic                str_haz;
  logic                hazard;
  logic                stall;
  lat_e                cls;
  logic [CW-1:0]       ld_val;
  logic [PERF_W-1:0]   perf;

  assign run = ~mem_hold;
  assign cls = lat_class(id_is_load, id_is_md);

  // ALU results are forwarded, so they
  // reload the counter with zero.
  always_comb begin
    ld_val = '0;
    case (cls)
      LAT_LOAD: ld_val = CW'(LOAD_LAT);
      LAT_MD:   ld_val = CW'(MD_LAT);
      default:  ld_val = '0;
    endcase
  end

  // $0 is hardwired, so it never gets a counter.
  assign pend[0] = 1'b0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
    reg_countdown #(.CW(CW)) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .en     (run),
      .ld     (issue & id_rd_we &
               (id_rd == REG_W'(r))),
      .ld_val (ld_val),
      .busy   (pend[r])
    );
  end

  reg_countdown #(.CW(CW)) u_md (
    .clk    (clk),
    .rst    (rst),
    .en     (run),
    .ld     (issue & id_is_md),
    .ld_val (CW'(MD_LAT)),
    .busy   (md_busy)
  );

  assign raw = id_valid &
    ((id_rs_used & pend[id_rs]) |
     (id_rt_used & pend[id_rt]));
  assign waw = id_valid & id_rd_we & pend[id_rd];
  assign str_haz = id_valid & id_is_md & md_busy;
  assign hazard = raw | waw | str_haz;

  assign stall = hazard & ~flush;
  assign issue = id_valid & ~hazard & ~flush & run;
  assign pc_write = ~stall & run;
  assign if_id_write = ~stall & run;
  assign id_ex_bubble = (stall | flush) & run;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      perf <= '0;
    else if (stall & run & ~&perf)
      perf <= perf + PERF_W'(1);
  end

  assign stall_cycles = perf;

endmodule
